// File: rtl/count_combs.sv
`timescale 1ns/1ps
// count_combs: counts the "doubled" numbers (X written twice, X with no
// leading zero, e.g. 11, 1212, 123123) in the range 1..N, and reports the
// decimal digit count of N. This is a multicycle engine with no start strobe.
// A run starts whenever n_in differs from the last latched N while the engine
// is idle or done.
//
// Optional feature: define COUNT_COMBS_SUM_EN to make count_out report the sum
// of the qualifying doubled numbers instead of how many there are.
//
// Ports:
//   clock            sole clock, rising edge
//   reset            asynchronous, active-low reset
//   n_in             unsigned upper bound N
//   n_digs_in        digit-length filter L (0 = no limit)
//   digs_out         decimal digit count D of latched N (0 for N = 0)
//   count_out        result (count, or sum with COUNT_COMBS_SUM_EN)
//   count_out_valid  high while digs_out/count_out hold a finished result
module count_combs #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LONG_DATA_WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      n_in,
  input  logic [DATA_WIDTH-1:0]      n_digs_in,
  output logic [DATA_WIDTH-1:0]      digs_out,
  output logic [LONG_DATA_WIDTH-1:0] count_out,
  output logic                       count_out_valid
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned LW = LONG_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIGITS = 3'd1,
    S_HALF   = 3'd2,
    S_ACCUM  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         state;
  logic [DW-1:0]  n_lat;     // latched N
  logic [DW-1:0]  l_lat;     // latched digit-length filter
  logic [DW-1:0]  w;         // working copy for digit counting
  logic [DW-1:0]  d;         // running digit count
  logic [DW-1:0]  h;         // upper half of N
  logic [DW-1:0]  half_cnt;  // remaining divides in HALF
  logic [LW-1:0]  p;         // 10^(k-1) for the next full term
  logic [LW-1:0]  acc;       // accumulated full terms

  logic [LW-1:0]  mult_c;
  logic           fits_c;
  logic [LW-1:0]  upper_c;
  logic           part_en_c;
  logic           term_slot_c;
  logic           full_en_c;
  logic [LW-1:0]  full_term_c;
  logic [LW-1:0]  part_term_c;

  // Term arithmetic. With d = 2k, p = 10^(k-1) and mult_c = 10^k + 1.
  always_comb begin
    mult_c      = p * LW'(10) + LW'(1);
    fits_c      = (LW'(h) * mult_c) <= LW'(n_lat);
    upper_c     = fits_c ? LW'(h) : (LW'(h) - LW'(1));
    // d even and >= 2: during DIGITS this means D >= d+1, so the k = d/2
    // full range is guaranteed; in ACCUM it means D = 2k exactly.
    term_slot_c = (d >= DW'(2)) && !d[0];
    full_en_c   = (l_lat == '0) || (d <= l_lat);
    part_en_c   = term_slot_c && full_en_c;
`ifdef COUNT_COMBS_SUM_EN
    // Sum of X over [p, 10p-1] is (11p-1)*9p/2, scaled by 10^k+1.
    full_term_c = ((((p * LW'(11)) - LW'(1)) * (p * LW'(9))) >> 1) * mult_c;
    part_term_c = (((p + upper_c) * (upper_c - p + LW'(1))) >> 1) * mult_c;
`else
    full_term_c = p * LW'(9);
    part_term_c = upper_c - p + LW'(1);
`endif
  end

  // Control and datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      n_lat           <= '0;
      l_lat           <= '0;
      w               <= '0;
      d               <= '0;
      h               <= '0;
      half_cnt        <= '0;
      p               <= '0;
      acc             <= '0;
      digs_out        <= '0;
      count_out       <= '0;
      count_out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (n_in != n_lat) begin
            n_lat           <= n_in;
            l_lat           <= n_digs_in;
            w               <= n_in;
            d               <= '0;
            h               <= '0;
            half_cnt        <= '0;
            p               <= LW'(1);
            acc             <= '0;
            count_out_valid <= 1'b0;
            state           <= S_DIGITS;
          end
        end
        S_DIGITS: begin
          if (w != '0) begin
            w <= w / DW'(10);
            d <= d + DW'(1);
            // A digit beyond an even count d proves 2k < D for k = d/2.
            if (term_slot_c) begin
              if (full_en_c) begin
                acc <= acc + full_term_c;
              end
              p <= p * LW'(10);
            end
          end else if (term_slot_c) begin
            h        <= n_lat;
            half_cnt <= d >> 1;
            state    <= S_HALF;
          end else begin
            state <= S_ACCUM;
          end
        end
        S_HALF: begin
          h        <= h / DW'(10);
          half_cnt <= half_cnt - DW'(1);
          if (half_cnt == DW'(1)) begin
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          count_out       <= acc + (part_en_c ? part_term_c : '0);
          digs_out        <= d;
          count_out_valid <= 1'b1;
          state           <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_combs.sv
`timescale 1ns/1ps
// Bench for count_combs: a scoreboard of expected results (from an
// independent closed-form model) is filled as stimulus is driven and drained
// as results appear.
module tb_count_combs;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] n_in = '0;
  logic [DW-1:0] n_digs_in = '0;
  logic [DW-1:0] digs_out;
  logic [LW-1:0] count_out;
  logic          count_out_valid;

  count_combs #(.DATA_WIDTH(DW), .LONG_DATA_WIDTH(LW)) dut (
    .clock          (clock),
    .reset          (reset),
    .n_in           (n_in),
    .n_digs_in      (n_digs_in),
    .digs_out       (digs_out),
    .count_out      (count_out),
    .count_out_valid(count_out_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    string           name;
    int unsigned     digs;
    longint unsigned cnt;
    int unsigned     max_lat;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0;
  int              errors = 0;
  longint unsigned last_cnt = 0;
  int unsigned     last_digs = 0;

  function automatic int unsigned ref_digs(longint unsigned n);
    int unsigned c = 0;
    while (n != 0) begin
      n = n / 10;
      c++;
    end
    return c;
  endfunction

  // For each half-length k: X in [10^(k-1), 10^k-1] with X*(10^k+1) <= N.
  function automatic longint unsigned ref_result(longint unsigned n, longint unsigned l);
    int unsigned     dd = ref_digs(n);
    longint unsigned total = 0;
    longint unsigned lo = 1;
    for (int k = 1; 2 * k <= dd; k++) begin
      longint unsigned mult = lo * 10 + 1;
      longint unsigned hi = lo * 10 - 1;
      longint unsigned top = n / mult;
      if (top > hi) top = hi;
      if ((l == 0 || longint'(2 * k) <= l) && top >= lo) begin
`ifdef COUNT_COMBS_SUM_EN
        total += mult * (((lo + top) * (top - lo + 1)) / 2);
`else
        total += top - lo + 1;
`endif
      end
      lo = lo * 10;
    end
    return total;
  endfunction

  // Drive a new bound and record what should come out of it.
  task automatic drive(input string name, input longint unsigned n,
                       input longint unsigned l, input int lat_adj);
    exp_t e;
    n_in      = DW'(n);
    n_digs_in = DW'(l);
    e.name    = name;
    e.digs    = ref_digs(n);
    e.cnt     = ref_result(n, l);
    e.max_lat = unsigned'(int'(e.digs + e.digs / 2 + 5) + lat_adj);
    sb.push_back(e);
  endtask

  // Wait (bounded) for a fresh finished result; no checking here.
  task automatic wait_result(output bit ok, output int unsigned lat);
    lat = 0;
    while (count_out_valid === 1'b1 && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    while (count_out_valid !== 1'b1 && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    ok = (count_out_valid === 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (count_out_valid !== 1'b0 || digs_out !== '0 || count_out !== '0) begin
      errors++;
      $display("FAIL reset_state valid=%b digs=%0d count=%0d required 0/0/0",
               count_out_valid, digs_out, count_out);
    end
    reset = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (count_out_valid !== 1'b0 || count_out !== '0) begin
      errors++;
      $display("FAIL reset_no_run_n0 valid=%b count=%0d required 0/0",
               count_out_valid, count_out);
    end
  endtask

  task automatic test_count;
    longint unsigned tn[13] = '{2843, 2843, 1212, 1211, 12345, 10, 11, 99, 100,
                                123123, 123122, 0, 64'd4294967295};
    longint unsigned tl[13] = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 4, 6, 0, 0};
    for (int i = 0; i < 13; i++) begin
      exp_t        e;
      bit          ok;
      int unsigned lat;
      // An equal n_in never restarts, so step away first when repeating N.
      if (i > 0 && tn[i] == tn[i-1]) begin
        n_in = DW'(tn[i] + 1);
        repeat (20) @(negedge clock);
      end
      drive($sformatf("n%0d_l%0d", tn[i], tl[i]), tn[i], tl[i], 0);
      wait_result(ok, lat);
      e = sb.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s timeout after %0d cycles", e.name, lat);
      end else begin
        checks++;
        if (digs_out !== DW'(e.digs)) begin
          errors++;
          $display("FAIL %s digs got %0d required %0d", e.name, digs_out, e.digs);
        end
        checks++;
        if (count_out !== LW'(e.cnt)) begin
          errors++;
          $display("FAIL %s count got %0d required %0d", e.name, count_out, e.cnt);
        end
        checks++;
        if (lat > e.max_lat) begin
          errors++;
          $display("FAIL %s latency got %0d required <= %0d", e.name, lat, e.max_lat);
        end
      end
      last_cnt  = e.cnt;
      last_digs = e.digs;
    end
  endtask

  task automatic test_no_restart;
    // Same N with a different filter must leave the result untouched.
    n_digs_in = DW'(2);
    repeat (6) @(negedge clock);
    checks++;
    if (count_out_valid !== 1'b1 || count_out !== LW'(last_cnt) ||
        digs_out !== DW'(last_digs)) begin
      errors++;
      $display("FAIL no_restart valid=%b count=%0d digs=%0d required 1/%0d/%0d",
               count_out_valid, count_out, digs_out, last_cnt, last_digs);
    end
  endtask

  task automatic test_reset_mid;
    exp_t        e;
    bit          ok;
    int unsigned lat;
    n_in      = DW'(98765432);
    n_digs_in = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (count_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_valid got %b required 0", count_out_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (count_out_valid !== 1'b0 || digs_out !== '0 || count_out !== '0) begin
      errors++;
      $display("FAIL async_abort valid=%b digs=%0d count=%0d required 0/0/0",
               count_out_valid, digs_out, count_out);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    drive("restart_98765432", 98765432, 0, 0);
    wait_result(ok, lat);
    e = sb.pop_front();
    checks++;
    if (!ok || digs_out !== DW'(e.digs) || count_out !== LW'(e.cnt) || lat > e.max_lat) begin
      errors++;
      $display("FAIL %s ok=%b digs=%0d count=%0d lat=%0d required digs %0d count %0d lat <= %0d",
               e.name, ok, digs_out, count_out, lat, e.digs, e.cnt, e.max_lat);
    end
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    bit          ok;
    int unsigned lat;
    drive("first_2843", 2843, 0, -3);
    repeat (3) @(negedge clock);
    // Mid-run change: must not disturb the current run.
    drive("second_1212", 1212, 0, -1);
    wait_result(ok, lat);
    e = sb.pop_front();
    checks++;
    if (!ok || digs_out !== DW'(e.digs) || count_out !== LW'(e.cnt) || lat > e.max_lat) begin
      errors++;
      $display("FAIL %s ok=%b digs=%0d count=%0d lat=%0d required digs %0d count %0d lat <= %0d",
               e.name, ok, digs_out, count_out, lat, e.digs, e.cnt, e.max_lat);
    end
    @(negedge clock);
    checks++;
    if (count_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL auto_restart_valid got %b required 0", count_out_valid);
    end
    wait_result(ok, lat);
    e = sb.pop_front();
    checks++;
    if (!ok || digs_out !== DW'(e.digs) || count_out !== LW'(e.cnt) || lat > e.max_lat) begin
      errors++;
      $display("FAIL %s ok=%b digs=%0d count=%0d lat=%0d required digs %0d count %0d lat <= %0d",
               e.name, ok, digs_out, count_out, lat, e.digs, e.cnt, e.max_lat);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d required 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_no_restart();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
